// File: rtl/maze_responder_pkg.sv
// Shared definitions for the maze responder: FSM state encoding and default geometry.
package maze_responder_pkg;

  localparam int DIM_W_DEF = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } maze_state_t;

endpackage

// File: rtl/maze_cell_array.sv
// N x N maze cell storage: one masked row-wide synchronous write port and one
// registered single-cell read port. Cell contents are never reset.
module maze_cell_array
  import maze_responder_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DIM_W-1:0]        wy,
  input  logic [(2**DIM_W)-1:0]   wmask,
  input  logic [(2**DIM_W)-1:0]   wdata,
  input  logic                    re,
  input  logic                    rforce,
  input  logic [DIM_W-1:0]        rx,
  input  logic [DIM_W-1:0]        ry,
  output logic                    rdata
);

  localparam int N = 2**DIM_W;

  logic [N-1:0] mem_r [N];
  logic         rdata_r;

  // Masked row write; a full mask loads a whole row, a one-hot mask updates one cell.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (we && wmask[i]) begin
        mem_r[wy][i] <= wdata[i];
      end
    end
  end

  // Registered read; sees the pre-write value when the same cell is written this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 1'b1;
    end else if (re) begin
      rdata_r <= rforce ? 1'b1 : mem_r[ry][rx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/maze_responder.sv
// Maze memory serving a rat's cell reads/writes after a row-by-row load.
// Optional wall write protection is enabled by defining MAZE_WRITE_PROTECT_EN.
module maze_responder
  import maze_responder_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RD,
  input  logic                  WR,
  input  logic [DIM_W-1:0]      X,
  input  logic [DIM_W-1:0]      Y,
  input  logic                  Din,
  output logic                  Dout,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [(2**DIM_W)-1:0] ld_row,
  output logic                  ready,
  output logic                  wr_err
);

  localparam int              N        = 2**DIM_W;
  localparam logic [DIM_W-1:0] LAST_ROW = {DIM_W{1'b1}};
  localparam logic [DIM_W-1:0] ROW_INC  = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     CELL0    = {{(N-1){1'b0}}, 1'b1};

  maze_state_t      state_r;
  logic [DIM_W-1:0] cnt_r;
  logic             ready_r;

  logic             load_wr_s;
  logic             rat_wr_s;
  logic             wall_hit_s;
  logic             we_s;
  logic [DIM_W-1:0] wy_s;
  logic [N-1:0]     wmask_s;
  logic [N-1:0]     wdata_s;
  logic             rforce_s;

  // ld_start wins over ld_valid in the same cycle, so a restart never writes a row.
  assign load_wr_s = (state_r == LOAD) && ld_valid && !ld_start;
  assign rat_wr_s  = (state_r == SERVE) && WR && !wall_hit_s;
  assign rforce_s  = (state_r != SERVE);

  // Select the single array write port between the loader and the rat.
  always_comb begin
    we_s    = 1'b0;
    wy_s    = {DIM_W{1'b0}};
    wmask_s = {N{1'b0}};
    wdata_s = {N{1'b0}};
    if (load_wr_s) begin
      we_s    = 1'b1;
      wy_s    = cnt_r;
      wmask_s = {N{1'b1}};
      wdata_s = ld_row;
    end else if (rat_wr_s) begin
      we_s    = 1'b1;
      wy_s    = Y;
      wmask_s = CELL0 << X;
      wdata_s = {N{Din}};
    end else begin
      we_s    = 1'b0;
    end
  end

  // Load/serve control FSM with the row counter and registered ready flag.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r <= EMPTY;
      cnt_r   <= {DIM_W{1'b0}};
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (ld_start) begin
            state_r <= LOAD;
            cnt_r   <= {DIM_W{1'b0}};
            ready_r <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_start) begin
            cnt_r <= {DIM_W{1'b0}};
          end else if (ld_valid) begin
            cnt_r <= cnt_r + ROW_INC;
            if (cnt_r == LAST_ROW) begin
              state_r <= SERVE;
              ready_r <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (ld_start) begin
            state_r <= LOAD;
            cnt_r   <= {DIM_W{1'b0}};
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= EMPTY;
          cnt_r   <= {DIM_W{1'b0}};
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_r;

`ifdef MAZE_WRITE_PROTECT_EN
  logic [N-1:0] wall_r [N];
  logic         wr_err_r;

  // Wall map mirrors the loaded rows and is never touched by rat writes.
  always_ff @(posedge clk) begin
    if (load_wr_s) begin
      wall_r[cnt_r] <= ld_row;
    end
  end

  // One-cycle error pulse for each rejected rat write.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= (state_r == SERVE) && WR && wall_hit_s;
    end
  end

  assign wall_hit_s = wall_r[Y][X];
  assign wr_err     = wr_err_r;
`else
  assign wall_hit_s = 1'b0;
  assign wr_err     = 1'b0;
`endif

  maze_cell_array #(
    .DIM_W (DIM_W)
  ) u_cells (
    .clk    (clk),
    .rst    (RST),
    .we     (we_s),
    .wy     (wy_s),
    .wmask  (wmask_s),
    .wdata  (wdata_s),
    .re     (RD),
    .rforce (rforce_s),
    .rx     (X),
    .ry     (Y),
    .rdata  (Dout)
  );

endmodule
